// File: rtl/bit_diff_feeder.sv
// bit_diff_feeder: buffers words in a small FIFO and sequences them one at
// a time through an external bit-difference core, returning each result.
module bit_diff_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int RW    = $clog2(2*WIDTH+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 core_go,
  output logic [WIDTH-1:0]     core_data,
  input  logic                 core_done,
  input  logic signed [RW-1:0] core_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [RW-1:0] out_result,
  output logic [WIDTH-1:0]     out_data,
  output logic                 error
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int WW = $clog2(WIDTH+5);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DROP,
    WAIT_DONE,
    OUTPUT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] op_r;
  logic [WW-1:0]    wd;
  logic             push;
  logic             pop;
  logic             expired;

  assign in_ready  = (count != CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign core_data = op_r;
  assign expired   = (wd == WW'(WIDTH+3));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // WAIT_DROP hides a done level still high from the previous operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_r       <= '0;
      core_go    <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_data   <= '0;
      error      <= 1'b0;
      wd         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            op_r    <= mem[rd_ptr];
            core_go <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          core_go <= 1'b0;
          wd      <= '0;
          state   <= WAIT_DROP;
        end
        WAIT_DROP: begin
          wd <= wd + 1'b1;
          if (expired) begin
            error <= 1'b1;
            state <= IDLE;
          end else if (!core_done) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          wd <= wd + 1'b1;
          if (core_done) begin
            out_result <= core_result;
            out_data   <= op_r;
            out_valid  <= 1'b1;
            state      <= OUTPUT;
          end else if (expired) begin
            error <= 1'b1;
            state <= IDLE;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= state_t'(3'bxxx);
      endcase
    end
  end
endmodule

// File: tb/tb_bit_diff_feeder.sv
// tb_bit_diff_feeder: directed and random traffic through the feeder with a
// behavioural core model and a decoupled scoreboard.
module tb_bit_diff_feeder;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int RW    = $clog2(2*WIDTH+1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data = '0;
  logic                 core_go;
  logic [WIDTH-1:0]     core_data;
  logic                 core_done;
  logic signed [RW-1:0] core_result;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [RW-1:0] out_result;
  logic [WIDTH-1:0]     out_data;
  logic                 error;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               r;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bit_diff_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RW(RW)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .core_go(core_go),
    .core_data(core_data),
    .core_done(core_done),
    .core_result(core_result),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_data(out_data),
    .error(error)
  );

  function automatic int diff(input logic [WIDTH-1:0] d);
    return 2 * $countones(d) - WIDTH;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Core model: stale done for m_stale cycles after go, then low,
  // then the new result held high m_lat cycles after that window.
  int               k = 1000;
  int               m_stale = 0;
  int               m_lat = 1;
  int               old_res = 0;
  logic [WIDTH-1:0] m_op = '0;
  int               cfg_stale = 0;
  int               cfg_lat = 1;
  bit               cfg_rand = 1'b1;
  bit               hang = 1'b0;

  always @(posedge clk) begin
    if (core_go) begin
      old_res <= diff(m_op);
      m_op    <= core_data;
      k       <= 0;
      m_stale <= cfg_rand ? int'($urandom_range(0, 3)) : cfg_stale;
      m_lat   <= cfg_rand ? int'($urandom_range(1, 4)) : cfg_lat;
    end else if (k < 1000) begin
      k <= k + 1;
    end
  end

  assign core_done   = !hang && ((k < m_stale) || (k >= m_stale + m_lat));
  assign core_result = RW'((k < m_stale) ? old_res : diff(m_op));

  bit   rand_ready = 1'b0;
  logic ready_cfg = 1'b1;

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cfg;
  end

  initial begin
    exp_t                 e;
    bit                   hold;
    logic signed [RW-1:0] h_res;
    logic [WIDTH-1:0]     h_dat;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", out_valid, 1);
          check("hold_result", out_result, h_res);
          check("hold_data", out_data, h_dat);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: data %0d result %0d, required none",
                     out_data, out_result);
          end else begin
            e = exp_q.pop_front();
            check("result", out_result, e.r);
            check("data", out_data, e.d);
          end
        end
        hold  = out_valid && !out_ready;
        h_res = out_result;
        h_dat = out_data;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input bit track);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 300) begin
      step(1);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready 0, required 1");
    end else if (track) begin
      exp_q.push_back('{d, diff(d)});
    end
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      step(1);
      n++;
    end
    check({name, "_outstanding"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [WIDTH-1:0] words [4];
    int acc;
    int n;
    words[0] = 8'hFF;
    words[1] = 8'h00;
    words[2] = 8'hA5;
    words[3] = 8'h07;

    step(2);
    rst = 1'b0;
    step(1);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_core_go", core_go, 0);
    check("rst_error", error, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_data", out_data, 0);

    for (int i = 0; i < 4; i++) send(words[i], 1'b1);
    drain("directed");

    cfg_rand  = 1'b0;
    cfg_stale = 3;
    cfg_lat   = 2;
    for (int i = 0; i < 4; i++) send(WIDTH'($urandom), 1'b1);
    drain("stale_done");
    cfg_rand = 1'b1;

    ready_cfg = 1'b0;
    step(2);
    acc = 0;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'($urandom);
      if (in_ready) begin
        exp_q.push_back('{in_data, diff(in_data)});
        acc++;
      end
      step(1);
    end
    in_valid = 1'b0;
    check("bp_accepted", acc, 5);
    check("bp_in_ready", in_ready, 0);
    ready_cfg = 1'b1;
    drain("backpressure");

    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(WIDTH'($urandom), 1'b1);
      step($urandom_range(0, 2));
    end
    drain("random");
    rand_ready = 1'b0;
    step(2);

    hang = 1'b1;
    send(WIDTH'($urandom), 1'b0);
    n = 0;
    while (!core_go && n < 50) begin
      step(1);
      n++;
    end
    check("wd_go_seen", core_go, 1);
    n = 0;
    while (!error && n < 40) begin
      step(1);
      n++;
    end
    check("wd_cycles", n, 13);
    check("wd_error", error, 1);
    check("wd_no_output", out_valid, 0);
    hang = 1'b0;
    send(WIDTH'($urandom), 1'b1);
    drain("after_watchdog");
    check("error_sticky", error, 1);

    cfg_rand  = 1'b0;
    cfg_stale = 0;
    cfg_lat   = 6;
    send(8'h3C, 1'b0);
    send(8'hC3, 1'b0);
    send(8'h81, 1'b0);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_error", error, 0);
    step(15);
    cfg_rand = 1'b1;
    send(8'h0F, 1'b1);
    drain("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end
endmodule
